// File: rtl/onecold_pkg.sv
// Shared types and helpers for the one-cold key encoder.
// The optional auto-repeat feature lives in onecold_encoder (ONECOLD_AUTO_REPEAT_EN).
package onecold_pkg;

  localparam int KEY_W = 8;
  localparam logic [KEY_W-1:0] IDLE_PAT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Returns {multi, code}: lowest-numbered low bit wins; multi when more than one bit is low.
  function automatic logic [3:0] prio_encode(input logic [KEY_W-1:0] pat);
    logic [2:0] code;
    logic [3:0] zeros;
    code  = '0;
    zeros = '0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (!pat[i]) begin
        code  = 3'(i);
        zeros = zeros + 4'd1;
      end
    end
    return {(zeros > 4'd1), code};
  endfunction

endpackage

// File: rtl/onecold_sync_ff2.sv
// Parameterised two-flop synchronizer with a configurable reset value.
module sync_ff2 #(
  parameter int            W       = 8,
  parameter logic [W-1:0]  RST_VAL = '1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/onecold_encoder.sv
// Debounced priority encoder for active-low one-cold key lines.
// Optional auto-repeat while a key is held: define ONECOLD_AUTO_REPEAT_EN.
module onecold_encoder
  import onecold_pkg::*;
#(
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             nEn,
  input  logic [KEY_W-1:0] nKey,
  output logic [2:0]       code,
  output logic             valid,
  output logic             held,
  output logic             multi,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DEB_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("onecold_encoder: DEB_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  logic [KEY_W-1:0] w_s;
  state_t           r_state, w_state_nxt;
  logic [KEY_W-1:0] r_pat, w_pat_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_accept;
  logic             w_rep_fire;
  logic [3:0]       w_prio;
  logic [2:0]       r_code;
  logic             r_multi, r_valid, r_held;

  sync_ff2 #(.W(KEY_W), .RST_VAL(IDLE_PAT)) u_sync (
    .i_clk   (clk),
    .i_rst_n (nRst),
    .i_d     (nKey),
    .o_q     (w_s)
  );

  assign w_prio = prio_encode(r_pat);

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (nEn) begin
      // Disable beats everything, including a debounce finishing this edge.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_s != IDLE_PAT) begin
            w_state_nxt = DEBOUNCE;
            w_pat_nxt   = w_s;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        DEBOUNCE: begin
          if (w_s == IDLE_PAT) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_s == r_pat) begin
            if (r_cnt == DEB_LAST) begin
              w_state_nxt = PRESSED;
              w_accept    = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end else begin
            w_pat_nxt = w_s;
            w_cnt_nxt = CNT_ONE;
          end
        end
        PRESSED: begin
          if (w_s == IDLE_PAT) begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        RELEASE: begin
          if (w_s != IDLE_PAT) begin
            w_state_nxt = PRESSED;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

`ifdef ONECOLD_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES);

  logic [RW-1:0] r_rep, w_rep_nxt;

  // Counter restarts at 1 on every entry to PRESSED and is zero elsewhere.
  always_comb begin
    w_rep_nxt  = '0;
    w_rep_fire = 1'b0;
    if (w_state_nxt == PRESSED) begin
      if (r_state != PRESSED) begin
        w_rep_nxt = RW'(1);
      end else if (r_rep == REP_LAST) begin
        w_rep_nxt  = RW'(1);
        w_rep_fire = 1'b1;
      end else begin
        w_rep_nxt = r_rep + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_rep <= '0;
    else       r_rep <= w_rep_nxt;
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_pat   <= IDLE_PAT;
      r_cnt   <= '0;
      r_code  <= 3'd0;
      r_multi <= 1'b0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_accept | w_rep_fire;
      r_held  <= (w_state_nxt == PRESSED);
      if (w_accept) begin
        r_code  <= w_prio[2:0];
        r_multi <= w_prio[3];
      end
    end
  end

  assign code      = r_code;
  assign multi     = r_multi;
  assign valid     = r_valid;
  assign held      = r_held;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_onecold_encoder.sv
// Directed testbench for onecold_encoder with DEB_CYCLES = 16.
module tb_onecold_encoder;

  logic       clk;
  logic       nRst;
  logic       nEn;
  logic [7:0] nKey;
  logic [2:0] code;
  logic       valid;
  logic       held;
  logic       multi;
  logic [1:0] dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int vcnt     = 0;
  int vbase;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd2;

  onecold_encoder #(.DEB_CYCLES(16), .REPEAT_CYCLES(64)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .nEn       (nEn),
    .nKey      (nKey),
    .code      (code),
    .valid     (valid),
    .held      (held),
    .multi     (multi),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (valid === 1'b1) vcnt++;

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic release_keys();
    nKey = 8'hFF;
    step(25);
  endtask

  initial begin
    nRst = 1'b0;
    nEn  = 1'b0;
    nKey = 8'hFF;
    #3;
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_held", 32'(held), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    step(2);
    nRst = 1'b1;

    // 1: idle lines
    step(100);
    chk("t1_vcnt", 32'(vcnt), 32'd0);
    chk("t1_code", 32'(code), 32'd0);
    chk("t1_held", 32'(held), 32'd0);
    chk("t1_multi", 32'(multi), 32'd0);

    // 2: single key 3, latency and release
    nKey = 8'b1111_0111;
    step(17);
    chk("t2_early_valid", 32'(valid), 32'd0);
    step(1);
    chk("t2_valid", 32'(valid), 32'd1);
    chk("t2_code", 32'(code), 32'd3);
    chk("t2_multi", 32'(multi), 32'd0);
    chk("t2_held", 32'(held), 32'd1);
    step(1);
    chk("t2_pulse_len", 32'(valid), 32'd0);
    chk("t2_vcnt", 32'(vcnt), 32'd1);
    nKey = 8'hFF;
    step(16);
    chk("t2_rel_held", 32'(held), 32'd0);
    step(4);
    chk("t2_rel_state", 32'(dbg_state), 32'(ST_IDLE));
    step(5);

    // 3: bouncing key 0
    vbase = vcnt;
    for (int i = 0; i < 4; i++) begin
      nKey = 8'b1111_1110;
      step(5);
      nKey = 8'hFF;
      step(3);
    end
    chk("t3_bounce_vcnt", 32'(vcnt - vbase), 32'd0);
    nKey = 8'b1111_1110;
    step(17);
    chk("t3_early_valid", 32'(valid), 32'd0);
    step(1);
    chk("t3_valid", 32'(valid), 32'd1);
    chk("t3_code", 32'(code), 32'd0);
    step(5);
    chk("t3_vcnt", 32'(vcnt - vbase), 32'd1);
    release_keys();

    // 4: multi-key, then extra key while held
    vbase = vcnt;
    nKey = 8'b0101_1111;
    step(18);
    chk("t4_valid", 32'(valid), 32'd1);
    chk("t4_code", 32'(code), 32'd5);
    chk("t4_multi", 32'(multi), 32'd1);
    nKey = 8'b0101_1110;
    step(30);
    chk("t4_add_vcnt", 32'(vcnt - vbase), 32'd1);
    chk("t4_add_code", 32'(code), 32'd5);
    chk("t4_add_held", 32'(held), 32'd1);
    release_keys();

    // 5: disable mid-debounce, re-enable with key still down
    vbase = vcnt;
    nKey = 8'b1011_1111;
    step(8);
    nEn = 1'b1;
    step(30);
    chk("t5_dis_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("t5_dis_vcnt", 32'(vcnt - vbase), 32'd0);
    chk("t5_dis_code", 32'(code), 32'd5);
    nEn = 1'b0;
    step(15);
    chk("t5_early_valid", 32'(valid), 32'd0);
    step(1);
    chk("t5_valid", 32'(valid), 32'd1);
    chk("t5_code", 32'(code), 32'd6);
    chk("t5_multi", 32'(multi), 32'd0);
    release_keys();

    // 5b: disable on the very edge a debounce would complete
    vbase = vcnt;
    nKey = 8'b1111_1101;
    step(17);
    nEn = 1'b1;
    step(1);
    chk("t5b_valid", 32'(valid), 32'd0);
    chk("t5b_state", 32'(dbg_state), 32'(ST_IDLE));
    step(5);
    chk("t5b_vcnt", 32'(vcnt - vbase), 32'd0);
    chk("t5b_code", 32'(code), 32'd6);
    nEn = 1'b0;
    release_keys();

    // 6: asynchronous reset while pressed
    nKey = 8'b1110_1111;
    step(20);
    chk("t6_pre_code", 32'(code), 32'd4);
    chk("t6_pre_state", 32'(dbg_state), 32'(ST_PRESSED));
    #2;
    nRst = 1'b0;
    #1;
    chk("t6_rst_held", 32'(held), 32'd0);
    chk("t6_rst_code", 32'(code), 32'd0);
    chk("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    nKey = 8'hFF;
    step(3);
    nRst = 1'b1;
    step(5);

`ifdef ONECOLD_AUTO_REPEAT_EN
    nKey = 8'b1111_1011;
    step(18);
    chk("ar_valid0", 32'(valid), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step(63);
      chk("ar_gap", 32'(valid), 32'd0);
      step(1);
      chk("ar_repeat", 32'(valid), 32'd1);
      chk("ar_code", 32'(code), 32'd2);
    end
    release_keys();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
